// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and constants for the CPU memory arbiter
// Contents: arbiter state encoding, requester IDs.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic GNT_INSTR = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/cpu_rr_pick2.sv
// rtl/cpu_rr_pick2.sv - combinational two-way round-robin chooser
// Ports: req[0]=instruction, req[1]=data; last = previous winner;
//        valid = any request; winner = chosen requester ID.
module cpu_rr_pick2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = GNT_INSTR;
        if (&req) begin
            // tie: whoever did not win last time goes now
            winner = (last == GNT_DATA) ? GNT_INSTR : GNT_DATA;
        end else if (req[1]) begin
            winner = GNT_DATA;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
// Ports: clk/rst (sync, active-high); i_* instruction requester; d_* data
//        requester; mem_* single-port memory; busy = transaction in flight.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ack,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   pick_valid;
    logic   pick_winner;
    logic   capture;

    cpu_rr_pick2 u_pick (
        .req   ({d_req, i_req}),
        .last  (last_grant),
        .valid (pick_valid),
        .winner(pick_winner)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    // zero-wait memory answers in the grant cycle
                    if (mem_rvalid) begin
                        state_nxt = ST_RESP;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = ST_RESP;
                    capture   = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // last_grant doubles as "current owner" once a transaction has started
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GNT_DATA;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state   <= state_nxt;
            mem_req <= (state_nxt == ST_REQ);
            i_ack   <= capture && (last_grant == GNT_INSTR);
            d_ack   <= capture && (last_grant == GNT_DATA);

            if ((state == ST_IDLE) && pick_valid) begin
                last_grant <= pick_winner;
                if (pick_winner == GNT_DATA) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_wstrb <= d_wstrb;
                end else begin
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                    mem_wstrb <= '0;
                end
            end

            if (capture) begin
                if (last_grant == GNT_DATA) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a ^ 32'h5A5A_0000) + 32'h11;
    endfunction

    // ---------------- memory responder ----------------
    logic        auto_mem = 1'b1;
    int          gnt_dly  = 0;
    int          rv_dly   = 1;
    int          g_cnt    = 0;
    int          rv_cnt   = 0;
    logic        rv_pend  = 1'b0;
    logic [31:0] saved_addr;

    always @(negedge clk) begin
        if (auto_mem) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_of(saved_addr);
                    rv_pend    = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (mem_req) begin
                if (g_cnt == gnt_dly) begin
                    mem_gnt    = 1'b1;
                    g_cnt      = 0;
                    saved_addr = mem_addr;
                    if (rv_dly == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rd_of(saved_addr);
                    end else begin
                        rv_pend = 1'b1;
                        rv_cnt  = rv_dly - 1;
                    end
                end else begin
                    g_cnt++;
                end
            end
        end else begin
            g_cnt   = 0;
            rv_pend = 1'b0;
        end
    end

    // ---------------- transaction-level model ----------------
    logic        m_open, m_accepted, m_ack, last_d;
    logic        e_mreq, e_iack, e_dack;
    logic [31:0] e_addr, e_wdata, e_ird, e_drd;
    logic [3:0]  e_wstrb;

    int mreq_cnt, iack_cnt, dack_cnt, busy_cnt;
    int ack_log[$];

    task automatic model_finish();
        if (last_d) e_drd = mem_rdata;
        else        e_ird = mem_rdata;
        m_open = 1'b0;
        m_ack  = 1'b1;
        e_iack = !last_d;
        e_dack = last_d;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_open = 0; m_accepted = 0; m_ack = 0; last_d = 1;
            e_mreq = 0; e_iack = 0; e_dack = 0;
            e_addr = 0; e_wdata = 0; e_wstrb = 0; e_ird = 0; e_drd = 0;
        end else begin
            e_iack = 0;
            e_dack = 0;
            if (m_ack) begin
                m_ack = 0;
            end else if (!m_open) begin
                if (i_req || d_req) begin
                    last_d     = (i_req && d_req) ? !last_d : d_req;
                    e_addr     = last_d ? d_addr : i_addr;
                    e_wdata    = last_d ? d_wdata : 32'h0;
                    e_wstrb    = last_d ? d_wstrb : 4'h0;
                    e_mreq     = 1;
                    m_open     = 1;
                    m_accepted = 0;
                end
            end else if (!m_accepted) begin
                if (mem_gnt) begin
                    e_mreq     = 0;
                    m_accepted = 1;
                    if (mem_rvalid) model_finish();
                end
            end else if (mem_rvalid) begin
                model_finish();
            end
        end
        #2;
        chk("mem_req",   64'(mem_req),   64'(e_mreq));
        chk("mem_addr",  64'(mem_addr),  64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
        chk("i_ack",     64'(i_ack),     64'(e_iack));
        chk("d_ack",     64'(d_ack),     64'(e_dack));
        chk("i_rdata",   64'(i_rdata),   64'(e_ird));
        chk("d_rdata",   64'(d_rdata),   64'(e_drd));
        chk("busy",      64'(busy),      64'(m_open || m_ack));
        if (mem_req) mreq_cnt++;
        if (i_ack) begin iack_cnt++; ack_log.push_back(0); end
        if (d_ack) begin dack_cnt++; ack_log.push_back(1); end
        if (busy) busy_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_counts();
        mreq_cnt = 0; iack_cnt = 0; dack_cnt = 0; busy_cnt = 0;
        ack_log.delete();
    endtask

    task automatic wait_ack(input bit is_d, input int limit, output int cyc);
        cyc = 0;
        repeat (limit) begin
            @(negedge clk);
            cyc++;
            if (is_d ? d_ack : i_ack) return;
        end
        chk("ack_timeout", 64'd1, 64'd0);
        cyc = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        clear_counts();
        repeat (3) @(negedge clk);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_i_ack",   64'(i_ack),   64'd0);
        chk("rst_i_rdata", 64'(i_rdata), 64'd0);
        rst = 0;
        @(negedge clk);

        // instruction fetch, grant immediately, data one cycle later
        clear_counts();
        gnt_dly = 0; rv_dly = 1;
        i_addr = 32'h100; i_req = 1;
        wait_ack(0, 20, cyc);
        i_req = 0;
        chk("t1_latency", 64'(cyc), 64'd3);
        chk("t1_i_rdata", 64'(i_rdata), 64'h0050_0093);
        chk("t1_mem_req_cycles", 64'(mreq_cnt), 64'd1);
        repeat (2) @(negedge clk);
        chk("t1_i_ack_pulses", 64'(iack_cnt), 64'd1);
        chk("t1_d_ack_pulses", 64'(dack_cnt), 64'd0);

        // partial store, grant delayed three cycles
        clear_counts();
        gnt_dly = 3; rv_dly = 1;
        d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; d_req = 1;
        wait_ack(1, 30, cyc);
        d_req = 0;
        chk("t2_latency", 64'(cyc), 64'd6);
        chk("t2_mem_req_cycles", 64'(mreq_cnt), 64'd4);
        chk("t2_mem_wstrb", 64'(mem_wstrb), 64'h3);
        chk("t2_d_rdata", 64'(d_rdata), 64'h5A5A_2015);
        chk("t2_i_ack_pulses", 64'(iack_cnt), 64'd0);
        repeat (2) @(negedge clk);

        // stray rvalid while idle
        auto_mem = 0;
        clear_counts();
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 0;
        repeat (2) @(negedge clk);
        chk("t6_i_rdata", 64'(i_rdata), 64'h0050_0093);
        chk("t6_d_rdata", 64'(d_rdata), 64'h5A5A_2015);
        chk("t6_acks", 64'(iack_cnt + dack_cnt), 64'd0);
        chk("t6_busy_cycles", 64'(busy_cnt), 64'd0);
        auto_mem = 1;

        // both requesters held high from reset
        rst = 1;
        @(negedge clk);
        rst = 0;
        clear_counts();
        gnt_dly = 0; rv_dly = 1;
        i_addr = 32'h40; d_addr = 32'h3000; d_wdata = 32'h1111_2222; d_wstrb = 4'h0;
        i_req = 1; d_req = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack_log.size() >= 4) break;
        end
        i_req = 0; d_req = 0;
        chk("t3_ack_count", 64'(ack_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++) begin
            chk($sformatf("t3_order_%0d", k), 64'(ack_log[k]), 64'(k % 2));
        end
        chk("t3_i_rdata", 64'(i_rdata), 64'h5A5A_0051);
        chk("t3_d_rdata", 64'(d_rdata), 64'h5A5A_3011);
        repeat (2) @(negedge clk);

        // zero-wait memory
        clear_counts();
        gnt_dly = 0; rv_dly = 0;
        i_addr = 32'h200; i_req = 1;
        wait_ack(0, 20, cyc);
        i_req = 0;
        chk("t4_latency", 64'(cyc), 64'd2);
        repeat (2) @(negedge clk);
        chk("t4_busy_cycles", 64'(busy_cnt), 64'd2);
        chk("t4_i_rdata", 64'(i_rdata), 64'h5A5A_0211);

        // reset while waiting for the response
        clear_counts();
        gnt_dly = 0; rv_dly = 5;
        d_addr = 32'h44; d_wstrb = 4'h0; d_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_in_wait", 64'(busy), 64'd1);
        chk("t5_mem_req_in_wait", 64'(mem_req), 64'd0);
        rst = 1; auto_mem = 0; mem_gnt = 0; mem_rvalid = 0;
        @(negedge clk);
        rst = 0; d_req = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rvalid = 0;
        repeat (2) @(negedge clk);
        chk("t5_acks", 64'(iack_cnt + dack_cnt), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_mem_req", 64'(mem_req), 64'd0);
        chk("t5_mem_addr", 64'(mem_addr), 64'd0);
        chk("t5_d_rdata", 64'(d_rdata), 64'd0);
        chk("t5_i_rdata", 64'(i_rdata), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-port memory between the CPU instruction-fetch requester and the CPU data (load/store) requester.
- Lets the core run from a unified RAM.
- Round-robin arbitration, one transaction outstanding at a time.
- Registered memory-side outputs; the requester is told completion by a one-cycle ack pulse carrying read data.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses; the byte-strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  instruction read request; hold high with i_addr stable until i_ack
- i_addr  in  ADDR_WIDTH  instruction address
- i_ack  out  1  one-cycle pulse: instruction transaction complete
- i_rdata  out  DATA_WIDTH  fetched word, valid while i_ack=1
- d_req  in  1  data request; hold high with d_addr/d_wdata/d_wstrb stable until d_ack
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_wstrb  in  DATA_WIDTH/8  byte write enables; 0 means read
- d_ack  out  1  one-cycle pulse: data transaction complete
- d_rdata  out  DATA_WIDTH  load data, valid while d_ack=1; don't-care for writes
- mem_req  out  1  memory request valid
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables; always 0 for instruction grants
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  memory response valid; asserted for reads and for writes
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: synchronous on clk when rst=1; takes priority over all other activity.
  - Reset values: state=IDLE, mem_req=0, mem_addr/mem_wdata/mem_wstrb=0, i_ack=d_ack=0, i_rdata=d_rdata=0, last_grant=DATA, busy=0.
  - Reset mid-transaction: abandon the transaction, no ack issued. The memory is reset by the same rst.
- States:
  - IDLE: no transaction.
  - REQ: mem_req=1, waiting for mem_gnt.
  - WAIT: waiting for mem_rvalid.
  - RESP: ack pulse cycle.
- IDLE:
  - Winner selection:
    - Only i_req high: instruction wins.
    - Only d_req high: data wins.
    - Both high: the requester not equal to last_grant wins. After reset the instruction side therefore wins the first tie.
  - On a winner: latch that requester's addr/wdata/wstrb into the mem_* registers (instr: wdata=0, wstrb=0). Set mem_req=1, update last_grant, go to REQ.
  - No request: stay in IDLE.
- REQ: mem_* held stable.
  - mem_gnt=0: stay in REQ.
  - mem_gnt=1 and mem_rvalid=0: mem_req<=0, go to WAIT.
  - mem_gnt=1 and mem_rvalid=1 (zero-wait memory): mem_req<=0, capture mem_rdata, go to RESP.
- WAIT:
  - mem_rvalid=1: capture mem_rdata into the granted requester's rdata register, go to RESP.
  - Otherwise stay in WAIT. No timeout.
- RESP:
  - Granted requester's ack=1 for exactly this cycle; the other ack stays 0. Next state is IDLE.
  - rdata registers hold their value until the next capture.
- Timing:
  - Minimum latency, req sampled high to ack high: 2 cycles (IDLE->REQ->RESP).
  - Throughput: one transaction per 3 cycles minimum.
  - A req still high in the first IDLE cycle after RESP is a new transaction.
- Ignored inputs:
  - mem_rvalid in IDLE or RESP.
  - mem_gnt outside REQ.
  - req inputs outside IDLE. The non-granted requester simply waits; no starvation, because a tie alternates.
- Widths: all paths pass through unmodified; no address alignment or arithmetic is done here.

Decomposition:
- Shared package cpu_mem_pkg:
  - state encoding constants ST_IDLE, ST_REQ, ST_WAIT, ST_RESP (2 bits)
  - requester IDs GNT_INSTR=1'b0, GNT_DATA=1'b1
- One natural sub-module: cpu_rr_pick2. Combinational 2-way round-robin chooser.
  - Inputs: req[1:0], last.
  - Outputs: valid, winner.
- The FSM and registers stay in cpu_mem_arbiter.

Test Plan:
- Reset, then i_req=1, i_addr=0x100, mem_gnt=1 in REQ, mem_rvalid one cycle later with rdata=0x00500093 -> mem_req high 1 cycle, mem_wstrb=0, i_ack pulse 1 cycle with i_rdata=0x00500093; d_ack never high.
- d_req store: d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_gnt delayed 3 cycles -> mem_addr/wdata/wstrb stable for all 4 REQ cycles; d_ack after rvalid.
- Both requesters held high for 4 transactions from reset -> grant order I, D, I, D.
- Zero-wait memory (mem_gnt and mem_rvalid together in the first REQ cycle) -> ack exactly 2 cycles after req was sampled, busy high for 2 cycles.
- Assert rst during WAIT, then mem_rvalid=1 next cycle -> no ack; outputs at reset values; state IDLE.
- mem_rvalid pulsed while IDLE with no requests -> no ack; rdata registers unchanged.
